// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC. Issues one instruction-bus request at a time and buffers
// the returned word until the F/D register accepts it. Applies PC redirects
// from later stages. A redirect that arrives while a request is outstanding
// lets that request finish, then drops its data and fetches the new target.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   ireq         instruction-bus request {valid, addr}
//   iresp        instruction-bus response {addr_ok, data_ok, data}; addr_ok unused
//   redirect     restart fetch at redirect_pc
//   redirect_pc  restart address
//   stallF       F/D register refuses delivery this cycle
//   dataF_nxt    {valid, pc, raw_instr} toward the F/D register
//   fetch_cnt    delivered-instruction count (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN adds the fetch_cnt port and counter.
// All outputs are registered. Their next values are decoded from next state,
// so there is no path from iresp, redirect or stallF to any output.

package fetch_ctrl_pkg;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] raw_instr;
    } fetch_data_t;
endpackage

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output ibus_req_t        ireq,
    input  ibus_resp_t       iresp,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             stallF,
    output fetch_data_t      dataF_nxt
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]  fetch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, VALID} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [ILEN-1:0]   buf_instr_q, buf_instr_d;
    logic              handoff;
    ibus_req_t         ireq_d;
    fetch_data_t       data_d;

    // The bus address-phase acknowledge is not needed by this controller.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    // Next-state, next-PC and next-output decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        handoff     = 1'b0;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (iresp.data_ok) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = iresp.data;
                        state_d     = VALID;
                    end
                end else if (redirect) begin
                    tgt_d   = redirect_pc;
                    state_d = DISCARD;
                end
            end
            // Old request must complete before the new target can be issued.
            DISCARD: begin
                if (iresp.data_ok) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = REQ;
                end else if (redirect) begin
                    tgt_d = redirect_pc;
                end
            end
            // Redirect beats stall: buffered word is stale either way.
            VALID: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (!stallF) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                    handoff = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ireq_d.valid     = (state_d == REQ) || (state_d == DISCARD);
        ireq_d.addr      = pc_d;
        data_d.valid     = (state_d == VALID);
        data_d.pc        = buf_pc_d;
        data_d.raw_instr = buf_instr_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            ireq        <= '{valid: 1'b0, addr: RESET_PC};
            dataF_nxt   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            ireq        <= ireq_d;
            dataF_nxt   <= data_d;
        end
    end

`ifdef FETCH_PERF_EN
    // Delivered-instruction counter; redirect-dropped words are not counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
        end else if (handoff) begin
            fetch_cnt <= fetch_cnt + XLEN'(1);
        end
    end
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. A transaction-level model
// (request outstanding / stale / buffer held) predicts the outputs every
// cycle; "pin" checks hand-computed literals from the stimulus script.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stallF;
    fetch_data_t dataF_nxt;
`ifdef FETCH_PERF_EN
    logic [63:0] fetch_cnt;
`endif

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iresp       (iresp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stallF      (stallF),
        .dataF_nxt   (dataF_nxt)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic        armed = 1'b0;
    logic        m_gap, m_out, m_stale, m_has;
    logic [63:0] m_addr, m_tgt, m_bpc, m_cnt;
    logic [31:0] m_binstr;

    // Pinned literal expectation handed from the stimulus script
    int          pin_seq  = 0;
    int          pin_seen = 0;
    int          pin_sel  = 0;
    logic [63:0] pin_exp  = '0;

    always @(posedge clk) begin
        if (!reset) begin
            armed = 1'b1; m_gap = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_has = 1'b0;
            m_addr = RST_PC; m_tgt = '0; m_bpc = '0; m_binstr = '0; m_cnt = '0;
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_out = 1'b1;
        end else if (m_out) begin
            if (iresp.data_ok) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = redirect ? redirect_pc : m_tgt;
                end else if (redirect) begin
                    m_addr = redirect_pc;
                end else begin
                    m_out = 1'b0; m_has = 1'b1; m_bpc = m_addr; m_binstr = iresp.data;
                end
            end else if (redirect) begin
                m_stale = 1'b1;
                m_tgt   = redirect_pc;
            end
        end else if (m_has) begin
            if (redirect) begin
                m_has = 1'b0; m_out = 1'b1; m_addr = redirect_pc;
            end else if (!stallF) begin
                m_has = 1'b0; m_out = 1'b1; m_cnt = m_cnt + 64'd1; m_addr = m_addr + 64'd4;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model every cycle, plus any pending pinned literal
    always @(negedge clk) begin
        if (armed) begin
            check("ireq.valid", 64'(ireq.valid), 64'(m_out));
            if (m_out) check("ireq.addr", ireq.addr, m_addr);
            check("dataF.valid", 64'(dataF_nxt.valid), 64'(m_has));
            if (m_has) begin
                check("dataF.pc", dataF_nxt.pc, m_bpc);
                check("dataF.instr", 64'(dataF_nxt.raw_instr), 64'(m_binstr));
            end
`ifdef FETCH_PERF_EN
            check("fetch_cnt", fetch_cnt, m_cnt);
`endif
            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                case (pin_sel)
                    0: check("pin ireq.valid", 64'(ireq.valid), pin_exp);
                    1: check("pin ireq.addr", ireq.addr, pin_exp);
                    2: check("pin dataF.valid", 64'(dataF_nxt.valid), pin_exp);
                    3: check("pin dataF.pc", dataF_nxt.pc, pin_exp);
                    4: check("pin dataF.instr", 64'(dataF_nxt.raw_instr), pin_exp);
`ifdef FETCH_PERF_EN
                    5: check("pin fetch_cnt", fetch_cnt, pin_exp);
`endif
                    default: check("pin select", 64'(pin_sel), 64'd0);
                endcase
            end
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge
    task automatic step(input logic rst, input logic dok, input logic [31:0] d,
                        input logic rd, input logic [63:0] rpc, input logic st);
        reset           = rst;
        iresp.addr_ok   = 1'b0;
        iresp.data_ok   = dok;
        iresp.data      = d;
        redirect        = rd;
        redirect_pc     = rpc;
        stallF          = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic dok(input logic [31:0] d);
        step(1'b1, 1'b1, d, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic redir(input logic [63:0] rpc, input logic ok, input logic st);
        step(1'b1, ok, 32'hDEAD_BEEF, 1'b1, rpc, st);
    endtask

    // At most one pin per cycle; it is checked at the coming falling edge
    task automatic pin(input int sel, input logic [63:0] exp);
        pin_sel = sel;
        pin_exp = exp;
        pin_seq++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; iresp = '0; redirect = 1'b0; redirect_pc = '0; stallF = 1'b0;

        // Reset and the quiet cycle that follows it
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        pin(0, 64'd0);
        idle();                         pin(1, 64'h8000_0000);

        // Back-to-back fetches with a 1-cycle bus
        dok(32'h0000_0013);             pin(3, 64'h8000_0000);
        idle();                         pin(1, 64'h8000_0004);
        dok(32'h0010_0093);             pin(4, 64'h0010_0093);
        idle();                         pin(1, 64'h8000_0008);
        dok(32'h0020_0113);             pin(2, 64'd1);

        // Stall holds the buffered word
        step(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);  pin(0, 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);  pin(3, 64'h8000_0008);
        idle();                         pin(1, 64'h8000_000C);

        // Redirect while request outstanding: old address held until data_ok
        redir(64'h8000_1000, 1'b0, 1'b0);  pin(1, 64'h8000_000C);
        idle();                         pin(2, 64'd0);
        idle();
        dok(32'hBAD0_0001);             pin(1, 64'h8000_1000);
        dok(32'h0030_0193);             pin(3, 64'h8000_1000);

        // Redirect beats stall in VALID; buffer dropped
        redir(64'h8000_2000, 1'b0, 1'b1);  pin(2, 64'd0);

        // Redirect with data_ok in REQ, then redirects along the discard path
        redir(64'h8000_3000, 1'b1, 1'b0);  pin(1, 64'h8000_3000);
        redir(64'h8000_4000, 1'b0, 1'b0);  pin(1, 64'h8000_3000);
        redir(64'h8000_5000, 1'b0, 1'b0);
        dok(32'hBAD0_0002);             pin(1, 64'h8000_5000);
        dok(32'h0040_0213);             pin(4, 64'h0040_0213);
        idle();                         pin(1, 64'h8000_5004);

        // Redirect coincident with the stale data_ok wins over the saved target
        redir(64'h8000_6000, 1'b0, 1'b0);
        redir(64'h8000_7000, 1'b1, 1'b0);  pin(1, 64'h8000_7000);

        // PC wraps modulo 2^64
        redir(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);  pin(1, 64'hFFFF_FFFF_FFFF_FFFC);
        dok(32'h0050_0293);             pin(3, 64'hFFFF_FFFF_FFFF_FFFC);
        idle();                         pin(1, 64'h0);
        idle();
`ifdef FETCH_PERF_EN
        pin(5, 64'd5);
`endif

        // Reset mid-transaction
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);  pin(0, 64'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
`ifdef FETCH_PERF_EN
        pin(5, 64'd0);
`else
        pin(2, 64'd0);
`endif
        idle();                         pin(1, 64'h8000_0000);
        dok(32'h0060_0313);             pin(4, 64'h0060_0313);
        idle();                         pin(1, 64'h8000_0004);

        // Multi-cycle bus latency
        idle();
        idle();
        dok(32'h0070_0393);             pin(3, 64'h8000_0004);
        idle();                         pin(1, 64'h8000_0008);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
